// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction fetch front end with a DEPTH-entry {pc, instr} queue to decode.
// Request-to-output latency 2 cycles; issue is credit-gated so backpressure never drops or duplicates.
module instruction_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     fetch_en_i,
    input  logic                     redirect_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    output logic                     imem_req_o,
    output logic [XLEN-1:0]          imem_addr_o,
    input  logic [XLEN-1:0]          imem_rdata_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [XLEN-1:0]          out_instr_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];

    logic [AW+1:0]   credit_used;
    logic            push;
    logic            pop;

    // Credit check counts the outstanding read but not a same-cycle pop.
    assign credit_used = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
    assign imem_req_o  = rst_ni & fetch_en_i & ~redirect_i
                         & (credit_used < (AW+2)'(DEPTH));
    assign imem_addr_o = fetch_pc_q;

    assign out_valid_o = (count_q != '0) & ~redirect_i;
    assign out_pc_o    = mem_pc_q[rd_ptr_q];
    assign out_instr_o = mem_instr_q[rd_ptr_q];
    assign occupancy_o = count_q;

    assign push = inflight_q & ~redirect_i;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req_o) begin
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Storage is data-only; valid entries are tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue against a queue-based fetch model.
module tb_instruction_prefetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            fetch_en;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata = '0;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic [OW-1:0]   occupancy;

    always #5 clk = ~clk;

    instruction_prefetch_queue #(
        .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_pc_o(out_pc), .out_instr_o(out_instr), .occupancy_o(occupancy)
    );

    // Synchronous memory: word contents equal address / 4.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr >> 2;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: program-order list of buffered PCs plus one outstanding read.
    logic [31:0] mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pc;

    task automatic model_reset();
        mq.delete();
        m_pend = 1'b0;
        m_pc   = 32'h0;
    endtask

    task automatic step(input bit en, input bit rdy, input bit rd, input logic [31:0] rpc);
        bit e_req;
        bit e_vld;
        fetch_en    = en;
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge clk);
        e_req = en && !rd && ((mq.size() + int'(m_pend)) < DEPTH);
        e_vld = (mq.size() != 0) && !rd;
        check_eq("imem_req", 32'(imem_req), 32'(e_req));
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("out_valid", 32'(out_valid), 32'(e_vld));
        check_eq("occupancy", 32'(occupancy), 32'(mq.size()));
        if (e_vld) begin
            check_eq("out_pc", out_pc, mq[0]);
            check_eq("out_instr", out_instr, mq[0] >> 2);
        end
        if (rd) begin
            mq.delete();
            m_pend = 1'b0;
            m_pc   = rpc & 32'hFFFF_FFFC;
        end else begin
            if (e_vld && rdy) void'(mq.pop_front());
            if (m_pend) mq.push_back(m_pend_pc);
            m_pend    = e_req;
            m_pend_pc = m_pc;
            if (e_req) m_pc = m_pc + 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        fetch_en    = 1'b1;
        out_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (20) step(1, 1, 0, 0);

        repeat (10) step(1, 0, 0, 0);
        check_eq("full_occupancy", 32'(occupancy), DEPTH);
        check_eq("full_no_req", 32'(imem_req), 32'd0);
        repeat (20) step(1, 1, 0, 0);

        repeat (2) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0100);
        check_eq("redir_empty", 32'(occupancy), 32'd0);
        repeat (6) step(1, 1, 0, 0);

        step(1, 1, 1, 32'h0000_0203);
        repeat (6) step(1, 1, 0, 0);

        step(1, 1, 1, 32'hFFFF_FFF8);
        repeat (6) step(1, 1, 0, 0);

        repeat (4) step(0, 1, 0, 0);
        repeat (6) step(1, 1, 0, 0);

        // Asynchronous reset between clock edges with a read outstanding.
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_imem_req", 32'(imem_req), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        repeat (8) step(1, 1, 0, 0);

        repeat (3000) begin
            bit          en;
            bit          rdy;
            bit          rd;
            logic [31:0] rpc;
            en  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            step(en, rdy, rd, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_queue.md
# instruction_prefetch_queue

Parametrised instruction fetch front end: owns the fetch PC and issues sequential requests to the synchronous instruction memory (one-cycle read latency). It buffers returned instructions, with their PCs, in a DEPTH-entry FIFO and presents them to decode through a valid/ready handshake. It supports fetch enable, redirect (branch/jump) with flush and squash of in-flight reads, and backpressure without dropping or duplicating instructions. It replaces the fixed pc+4 free-running fetch path between the PC logic, instruction memory and decode.

## Interface
- XLEN, 32: PC and instruction width.
- DEPTH, 4: queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- fetch_en  in  1  when 1, new memory requests may be issued. When 0, no requests are issued and the queue still drains.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  XLEN  target PC; bits [1:0] are ignored and treated as 0.
- imem_req  out  1  read request this cycle.
- imem_addr  out  XLEN  request address (current fetch PC).
- imem_rdata  in  XLEN  read data, valid the cycle after imem_req.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_pc  out  XLEN  PC of the head entry.
- out_instr  out  XLEN  instruction of the head entry.
- occupancy  out  log2(DEPTH)+1  entries currently held.

## Operation
- State:
  - fetch_pc
  - inflight flag (request issued last cycle, not squashed)
  - inflight_pc
  - FIFO storage {pc, instr}[DEPTH]
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH
  - count
- Reset values:
  - fetch_pc = RESET_PC; inflight = 0; pointers = 0; count = 0.
  - Outputs: out_valid = 0, imem_req = 0, occupancy = 0.
  - out_pc and out_instr read the storage entry selected by rd_ptr and are not reset.
- Issue rule: imem_req = reset_n & fetch_en & ~redirect & (count + inflight < DEPTH). The credit check is conservative and ignores a pop in the same cycle.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4 (mod 2^XLEN, so 0xFFFF_FFFC wraps to 0); inflight <= 1; inflight_pc <= fetch_pc.
  - Otherwise: inflight <= 0.
- Fill: if inflight = 1 and redirect = 0, write {inflight_pc, imem_rdata} at wr_ptr and increment wr_ptr.
- Drain: out_valid = (count != 0) & ~redirect. A handshake (out_valid & out_ready) increments rd_ptr.
- Push and pop in the same cycle: both happen and count is unchanged.
- Full (count = DEPTH) cannot overflow: the credit rule guarantees a slot exists for every in-flight response.
- Redirect in cycle R:
  - Pointers and count are cleared; inflight <= 0.
  - The response arriving in R is discarded.
  - No request is issued in R; fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No handshake occurs in R.
  - Redirect overrides fetch_en, fill and pop.
- fetch_en low: fetch_pc holds. A response already in flight is still written. Requests resume in the cycle fetch_en returns high.
- Reset asserted mid-operation: all state returns to its reset values immediately (asynchronous). The next in-flight response is ignored because inflight = 0.

## Timing
- Reset released before edge 0 with fetch_en = 1:
  - Cycle 0: imem_req = 1, imem_addr = RESET_PC.
  - Cycle 1: data returns and is written at the end of the cycle.
  - Cycle 2: out_valid = 1, out_pc = RESET_PC.
- Request-to-output latency is 2 cycles.
- With out_ready held at 1, throughput is one instruction per cycle.
- Redirect pulse in cycle R: request for the target in R+1; out_valid = 1 with the target in R+3.
- Backpressure: if out_ready stays low, at most DEPTH entries accumulate. imem_req falls once count + inflight = DEPTH, and rises again in the cycle after a pop frees a credit.
- All outputs except imem_req and out_valid are register-driven. Those two also depend combinationally on redirect and fetch_en.

## Test plan
- Reset to RESET_PC = 0 with the memory returning addr/4 as data, fetch_en = 1, out_ready = 1 → out_pc = 0, 4, 8, 12… on consecutive cycles from cycle 2, each with out_instr = out_pc/4.
- out_ready = 0 for 10 cycles, DEPTH = 4 → occupancy reaches 4 and imem_req stays low afterwards. On release of out_ready: PCs 0, 4, 8, 12, 16… in order with no gap or duplicate.
- Redirect to 0x100 while the queue holds 3 entries and a read is in flight → queue empty in R+1, stale data never appears, and the next out_pc is 0x100 in R+3.
- redirect_pc = 0x203 → first fetched PC is 0x200. Fetch from 0xFFFF_FFF8 → PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- fetch_en drops with one read in flight → that entry is delivered, then no further requests; after fetch_en = 1 again the next PC continues sequentially.
- Reset asserted mid-burst (between clock edges) → out_valid and imem_req go to 0 immediately. After release, fetch restarts at RESET_PC and the in-flight data is dropped.
